// File: rtl/axil_adc_ctrl_if.sv
// -----------------------------------------------------------------------------
// axil_adc_ctrl_if
// AXI4-Lite bundle between a processor-side master and the ADC controller.
//   aw*  : write address channel   (awaddr, awvalid / awready)
//   w*   : write data channel      (wdata, wstrb, wvalid / wready)
//   b*   : write response channel  (bresp, bvalid / bready)
//   ar*  : read address channel    (araddr, arvalid / arready)
//   r*   : read data channel       (rdata, rresp, rvalid / rready)
// -----------------------------------------------------------------------------
interface axil_adc_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_adc_ctrl.sv
// -----------------------------------------------------------------------------
// axil_adc_ctrl
// AXI4-Lite slave controlling an external 8-bit parallel ADC. Divides aclk to
// produce adc_clk, runs single conversions on request and exposes the
// captured sample through four word registers:
//   0x00 CTL     [0] EN, [1] START (self-clearing, reads 0)
//   0x04 STAT    [0] BUSY, [1] DONE (sticky, write 1 to clear)
//   0x08 CLK_DIV [15:0] DIV (half period of adc_clk = DIV+1 aclk cycles)
//   0x0C DATA    [7:0] last captured sample
// Ports:
//   aclk     : system clock, rising edge
//   areset   : synchronous active-high reset
//   s_axi    : AXI4-Lite slave bundle (axil_adc_ctrl_if.slave)
//   adc_clk  : registered ADC sample clock
//   adc_data : ADC output, updated by the ADC after each adc_clk rise
// -----------------------------------------------------------------------------
module axil_adc_ctrl #(
    parameter int          ADDR_W  = 4,
    parameter int          LATENCY = 3,
    parameter logic [15:0] DIV_RST = 16'd4
) (
    input  logic           aclk,
    input  logic           areset,
    axil_adc_ctrl_if.slave s_axi,
    output logic           adc_clk,
    input  logic [7:0]     adc_data
);
    localparam int               CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] FALL_LAST = CNT_W'(LATENCY - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] REG_CTL  = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_DIV  = 2'd2;
    localparam logic [1:0] REG_DATA = 2'd3;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    // Bus-side state
    logic        awready_q, awready_d;
    logic        wready_q,  wready_d;
    logic        bvalid_q,  bvalid_d;
    logic [1:0]  bresp_q,   bresp_d;
    logic        arready_q, arready_d;
    logic        rvalid_q,  rvalid_d;
    logic [1:0]  rresp_q,   rresp_d;
    logic [31:0] rdata_q,   rdata_d;

    // Register file and datapath state
    logic             en_q,       en_d;
    logic [15:0]      div_q,      div_d;
    logic [15:0]      div_act_q,  div_act_d;   // divisor currently in use by the counter
    logic [15:0]      cnt_q,      cnt_d;
    logic             adc_clk_q,  adc_clk_d;
    logic [7:0]       data_q,     data_d;
    logic             done_q,     done_d;
    state_t           state_q,    state_d;
    logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;

    // Decode helpers
    logic        wr_mapped;
    logic        rd_mapped;
    logic [1:0]  wr_idx;
    logic [1:0]  rd_idx;
    logic        busy;
    logic        wrap;
    logic        fall;
    logic        start;
    logic        clr_done;
    logic [31:0] rd_word;

    // Anything above the four mapped words is an unmapped (SLVERR) offset.
    assign wr_mapped = (s_axi.awaddr >> 4) == '0;
    assign rd_mapped = (s_axi.araddr >> 4) == '0;
    assign wr_idx    = s_axi.awaddr[3:2];
    assign rd_idx    = s_axi.araddr[3:2];
    assign busy      = (state_q == S_WAIT);

    // The divider wraps when the count reaches the active divisor; a wrap
    // while adc_clk is high is the 1->0 toggle the conversion counts.
    assign wrap = en_q && (cnt_q == div_act_q);
    assign fall = wrap && adc_clk_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        awready_d  = 1'b0;
        wready_d   = 1'b0;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        arready_d  = 1'b0;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        en_d       = en_q;
        div_d      = div_q;
        div_act_d  = div_act_q;
        cnt_d      = cnt_q;
        adc_clk_d  = adc_clk_q;
        data_d     = data_q;
        done_d     = done_q;
        state_d    = state_q;
        fall_cnt_d = fall_cnt_q;
        start      = 1'b0;
        clr_done   = 1'b0;
        rd_word    = 32'h0;

        // ---------------- write path ----------------
        // Ready is raised only once both AW and W are presented, so the
        // register update happens on the single edge where both complete.
        if (s_axi.awvalid && s_axi.wvalid && !awready_q && !bvalid_q) begin
            awready_d = 1'b1;
            wready_d  = 1'b1;
        end

        if (awready_q) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_mapped ? RESP_OKAY : RESP_SLVERR;
            if (wr_mapped) begin
                case (wr_idx)
                    REG_CTL: begin
                        if (s_axi.wstrb[0]) begin
                            en_d  = s_axi.wdata[0];
                            start = s_axi.wdata[1];
                        end
                    end
                    REG_STAT: begin
                        if (s_axi.wstrb[0]) clr_done = s_axi.wdata[1];
                    end
                    REG_DIV: begin
                        if (s_axi.wstrb[0]) div_d[7:0]  = s_axi.wdata[7:0];
                        if (s_axi.wstrb[1]) div_d[15:8] = s_axi.wdata[15:8];
                    end
                    default: ;
                endcase
            end
        end else if (bvalid_q && s_axi.bready) begin
            bvalid_d = 1'b0;
        end

        // ---------------- read path ----------------
        case (rd_idx)
            REG_CTL:  rd_word = {31'h0, en_q};
            REG_STAT: rd_word = {30'h0, done_q, busy};
            REG_DIV:  rd_word = {16'h0, div_q};
            default:  rd_word = {24'h0, data_q};
        endcase

        if (s_axi.arvalid && !arready_q && !rvalid_q) arready_d = 1'b1;

        if (arready_q) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_mapped ? RESP_OKAY : RESP_SLVERR;
            rdata_d  = rd_mapped ? rd_word : 32'h0;
        end else if (rvalid_q && s_axi.rready) begin
            rvalid_d = 1'b0;
        end

        // ---------------- clock divider ----------------
        // A new divisor is only picked up on a wrap so the current half
        // period always completes with the old value.
        if (!en_q) begin
            cnt_d     = 16'h0;
            adc_clk_d = 1'b0;
            div_act_d = div_q;
        end else if (wrap) begin
            cnt_d     = 16'h0;
            adc_clk_d = !adc_clk_q;
            div_act_d = div_q;
        end else begin
            cnt_d = cnt_q + 16'h1;
        end

        // ---------------- conversion FSM ----------------
        if (clr_done) done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Uses the EN value being written so CTL=3 starts at once.
                if (start && en_d) begin
                    state_d    = S_WAIT;
                    fall_cnt_d = '0;
                    done_d     = 1'b0;
                end
            end
            S_WAIT: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (fall) begin
                    if (fall_cnt_q == FALL_LAST) begin
                        data_d  = adc_data;
                        done_d  = 1'b1;   // overrides a same-cycle W1C
                        state_d = S_IDLE;
                    end else begin
                        fall_cnt_d = fall_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values; reset is synchronous, sampled on the clock edge.
    always_ff @(posedge aclk) begin
        if (areset) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= 32'h0;
            en_q       <= 1'b0;
            div_q      <= DIV_RST;
            div_act_q  <= DIV_RST;
            cnt_q      <= 16'h0;
            adc_clk_q  <= 1'b0;
            data_q     <= 8'h0;
            done_q     <= 1'b0;
            state_q    <= S_IDLE;
            fall_cnt_q <= '0;
        end else begin
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            en_q       <= en_d;
            div_q      <= div_d;
            div_act_q  <= div_act_d;
            cnt_q      <= cnt_d;
            adc_clk_q  <= adc_clk_d;
            data_q     <= data_d;
            done_q     <= done_d;
            state_q    <= state_d;
            fall_cnt_q <= fall_cnt_d;
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;
    assign adc_clk       = adc_clk_q;
endmodule

// File: tb/tb_axil_adc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axil_adc_ctrl
// Directed bench for axil_adc_ctrl at aclk = 50 MHz. A behavioural ADC bumps
// adc_data shortly after every adc_clk rise and logs the value present at
// every adc_clk fall, giving the sample a conversion must capture.
// -----------------------------------------------------------------------------
module tb_axil_adc_ctrl;
    localparam int ADDR_W = 8;

    logic       aclk = 1'b0;
    logic       areset;
    logic       adc_clk;
    logic [7:0] adc_data;

    int vectors     = 0;
    int miscompares = 0;
    int fall_count  = 0;
    int hs_falls    = 0;
    logic [7:0] hist [0:4095];

    always #10 aclk = ~aclk;

    axil_adc_ctrl_if #(.ADDR_W(ADDR_W)) s_axi ();

    axil_adc_ctrl #(
        .ADDR_W (ADDR_W),
        .LATENCY(3),
        .DIV_RST(16'd4)
    ) dut (
        .aclk    (aclk),
        .areset  (areset),
        .s_axi   (s_axi),
        .adc_clk (adc_clk),
        .adc_data(adc_data)
    );

    // ADC model: output changes a little after each adc_clk rise.
    initial begin
        adc_data = 8'h00;
        forever begin
            @(posedge adc_clk);
            #2;
            adc_data = adc_data + 8'h1D;
        end
    end

    always @(negedge adc_clk) begin
        fall_count = fall_count + 1;
        if (fall_count < 4096) hist[fall_count] = adc_data;
    end

    // ---------------------------------------------------------------- bus tasks
    task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             output logic [1:0] resp);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        aw_done = 1'b0;
        w_done  = 1'b0;
        n       = 0;
        resp    = 2'bxx;
        @(negedge aclk);
        s_axi.awaddr = addr;
        s_axi.wdata  = data;
        s_axi.wstrb  = strb;
        while (!(aw_done && w_done)) begin
            if (n >= aw_dly && !aw_done) s_axi.awvalid = 1'b1;
            if (n >= w_dly && !w_done)   s_axi.wvalid  = 1'b1;
            aw_hs = s_axi.awvalid && s_axi.awready;
            w_hs  = s_axi.wvalid && s_axi.wready;
            @(posedge aclk);
            #1;
            if (aw_hs) begin
                s_axi.awvalid = 1'b0;
                aw_done       = 1'b1;
                hs_falls      = fall_count;
            end
            if (w_hs) begin
                s_axi.wvalid = 1'b0;
                w_done       = 1'b1;
            end
            n++;
            if (n > 60) begin
                $display("FAIL write_timeout addr=%h: no aw/w handshake within 60 cycles", addr);
                miscompares++;
                s_axi.awvalid = 1'b0;
                s_axi.wvalid  = 1'b0;
                return;
            end
            @(negedge aclk);
        end
        s_axi.bready = 1'b1;
        n = 0;
        while (!s_axi.bvalid) begin
            @(negedge aclk);
            n++;
            if (n > 60) begin
                $display("FAIL bvalid_timeout addr=%h: bvalid not seen within 60 cycles", addr);
                miscompares++;
                s_axi.bready = 1'b0;
                return;
            end
        end
        resp = s_axi.bresp;
        @(posedge aclk);
        #1;
        s_axi.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [ADDR_W-1:0] addr, output logic [1:0] resp,
                            output logic [31:0] data);
        int n;
        resp = 2'bxx;
        data = 'x;
        @(negedge aclk);
        s_axi.araddr  = addr;
        s_axi.arvalid = 1'b1;
        n = 0;
        while (!s_axi.arready) begin
            @(negedge aclk);
            n++;
            if (n > 60) begin
                $display("FAIL arready_timeout addr=%h: arready not seen within 60 cycles", addr);
                miscompares++;
                s_axi.arvalid = 1'b0;
                return;
            end
        end
        @(posedge aclk);
        #1;
        s_axi.arvalid = 1'b0;
        s_axi.rready  = 1'b1;
        @(negedge aclk);
        n = 0;
        while (!s_axi.rvalid) begin
            @(negedge aclk);
            n++;
            if (n > 60) begin
                $display("FAIL rvalid_timeout addr=%h: rvalid not seen within 60 cycles", addr);
                miscompares++;
                s_axi.rready = 1'b0;
                return;
            end
        end
        data = s_axi.rdata;
        resp = s_axi.rresp;
        @(posedge aclk);
        #1;
        s_axi.rready = 1'b0;
    endtask

    task automatic wait_falls(input int target);
        int n;
        n = 0;
        while (fall_count < target) begin
            @(negedge aclk);
            n++;
            if (n > 400) begin
                $display("FAIL fall_timeout: fall count %0d, wanted %0d", fall_count, target);
                miscompares++;
                return;
            end
        end
    endtask

    // adc_clk rise-to-rise period in aclk cycles, -1 if no two rises seen.
    task automatic measure_period(output int cyc);
        logic prev;
        int   n, t0;
        n   = 0;
        t0  = -1;
        cyc = -1;
        @(negedge aclk);
        prev = adc_clk;
        while (n < 200) begin
            @(negedge aclk);
            n++;
            if (!prev && adc_clk) begin
                if (t0 < 0) t0 = n;
                else begin
                    cyc = n - t0;
                    return;
                end
            end
            prev = adc_clk;
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        logic [1:0]  resp;
        logic [31:0] data;
        logic [9:0]  idle;
        areset        = 1'b1;
        s_axi.awaddr  = '0;
        s_axi.awvalid = 1'b0;
        s_axi.wdata   = '0;
        s_axi.wstrb   = '0;
        s_axi.wvalid  = 1'b0;
        s_axi.bready  = 1'b0;
        s_axi.araddr  = '0;
        s_axi.arvalid = 1'b0;
        s_axi.rready  = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        idle = {adc_clk, s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.arready,
                s_axi.rvalid, s_axi.bresp, s_axi.rresp};
        vectors++;
        if (idle !== 10'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b, expected 0", idle);
        end
        areset = 1'b0;

        axi_read(8'h00, resp, data);
        vectors++;
        if ({resp, data} !== {2'b00, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_ctl: got resp=%b data=%h, expected resp=00 data=0", resp, data);
        end
        axi_read(8'h08, resp, data);
        vectors++;
        if ({resp, data} !== {2'b00, 32'h4}) begin
            miscompares++;
            $display("FAIL reset_clkdiv: got resp=%b data=%h, expected resp=00 data=4", resp, data);
        end
        axi_read(8'h0C, resp, data);
        vectors++;
        if ({resp, data} !== {2'b00, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_data: got resp=%b data=%h, expected resp=00 data=0", resp, data);
        end
        axi_read(8'h04, resp, data);
        vectors++;
        if ({resp, data} !== {2'b00, 32'h0}) begin
            miscompares++;
            $display("FAIL reset_stat: got resp=%b data=%h, expected resp=00 data=0", resp, data);
        end
    endtask

    task automatic test_clock_div();
        logic [1:0] resp;
        int         cyc;
        axi_write(8'h08, 32'h4, 4'hF, 0, 0, resp);
        axi_write(8'h00, 32'h1, 4'hF, 0, 0, resp);
        measure_period(cyc);
        vectors++;
        if (cyc !== 10) begin
            miscompares++;
            $display("FAIL period_div4: got %0d aclk cycles, expected 10 (200 ns)", cyc);
        end
        axi_write(8'h08, 32'h0, 4'hF, 0, 0, resp);
        repeat (12) @(posedge aclk);
        measure_period(cyc);
        vectors++;
        if (cyc !== 2) begin
            miscompares++;
            $display("FAIL period_div0: got %0d aclk cycles, expected 2 (40 ns)", cyc);
        end
    endtask

    task automatic test_conversion();
        logic [1:0]  resp;
        logic [31:0] data;
        int          s;
        axi_write(8'h08, 32'h4, 4'hF, 0, 0, resp);
        repeat (12) @(posedge aclk);
        axi_write(8'h00, 32'h3, 4'hF, 0, 0, resp);
        s = hs_falls;
        wait_falls(s + 2);
        axi_read(8'h04, resp, data);
        vectors++;
        if (data !== 32'h1) begin
            miscompares++;
            $display("FAIL conv_busy: STAT got %h, expected 1 after 2 falls", data);
        end
        wait_falls(s + 3);
        axi_read(8'h04, resp, data);
        vectors++;
        if (data !== 32'h2) begin
            miscompares++;
            $display("FAIL conv_done: STAT got %h, expected 2 after 3 falls", data);
        end
        axi_read(8'h0C, resp, data);
        vectors++;
        if (data !== {24'h0, hist[s+3]}) begin
            miscompares++;
            $display("FAIL conv_data: DATA got %h, expected %h", data, {24'h0, hist[s+3]});
        end
        axi_read(8'h00, resp, data);
        vectors++;
        if (data !== 32'h1) begin
            miscompares++;
            $display("FAIL ctl_start_clears: CTL got %h, expected 1", data);
        end
    endtask

    task automatic test_start_ignored();
        logic [1:0]  resp;
        logic [31:0] data;
        logic [7:0]  exp_data;
        int          s;
        // START with EN=0: nothing begins, DONE stays set, clock held low.
        axi_write(8'h00, 32'h2, 4'hF, 0, 0, resp);
        repeat (15) @(negedge aclk);
        vectors++;
        if (adc_clk !== 1'b0) begin
            miscompares++;
            $display("FAIL en0_clk_low: adc_clk got %b, expected 0", adc_clk);
        end
        axi_read(8'h04, resp, data);
        vectors++;
        if (data !== 32'h2) begin
            miscompares++;
            $display("FAIL start_en0: STAT got %h, expected 2", data);
        end
        // START while BUSY must not restart the fall count.
        axi_write(8'h00, 32'h3, 4'hF, 0, 0, resp);
        s = hs_falls;
        wait_falls(s + 1);
        axi_write(8'h00, 32'h3, 4'hF, 0, 0, resp);
        wait_falls(s + 3);
        axi_read(8'h04, resp, data);
        vectors++;
        if (data !== 32'h2) begin
            miscompares++;
            $display("FAIL start_busy: STAT got %h, expected 2 (no restart)", data);
        end
        exp_data = hist[s+3];
        axi_read(8'h0C, resp, data);
        vectors++;
        if (data !== {24'h0, exp_data}) begin
            miscompares++;
            $display("FAIL start_busy_data: DATA got %h, expected %h", data, exp_data);
        end
        // W1C on DONE.
        axi_write(8'h04, 32'h2, 4'hF, 0, 0, resp);
        axi_read(8'h04, resp, data);
        vectors++;
        if (data !== 32'h0) begin
            miscompares++;
            $display("FAIL w1c_done: STAT got %h, expected 0", data);
        end
        // Clearing EN mid-conversion aborts and keeps the old sample.
        axi_write(8'h00, 32'h3, 4'hF, 0, 0, resp);
        s = hs_falls;
        wait_falls(s + 1);
        axi_write(8'h00, 32'h0, 4'hF, 0, 0, resp);
        axi_read(8'h04, resp, data);
        vectors++;
        if (data !== 32'h0) begin
            miscompares++;
            $display("FAIL abort_stat: STAT got %h, expected 0", data);
        end
        axi_read(8'h0C, resp, data);
        vectors++;
        if (data !== {24'h0, exp_data}) begin
            miscompares++;
            $display("FAIL abort_data: DATA got %h, expected %h", data, exp_data);
        end
    endtask

    task automatic test_bus_ordering();
        logic [1:0]  resp;
        logic [31:0] data;
        axi_write(8'h08, 32'h0000_1234, 4'hF, 0, 2, resp);
        vectors++;
        if (resp !== 2'b00) begin
            miscompares++;
            $display("FAIL aw_first_bresp: got %b, expected 00", resp);
        end
        axi_read(8'h08, resp, data);
        vectors++;
        if ({resp, data} !== {2'b00, 32'h1234}) begin
            miscompares++;
            $display("FAIL aw_first_data: got resp=%b data=%h, expected 00/1234", resp, data);
        end
        axi_write(8'h08, 32'hFFFF_FF55, 4'h1, 2, 0, resp);
        axi_read(8'h08, resp, data);
        vectors++;
        if ({resp, data} !== {2'b00, 32'h1255}) begin
            miscompares++;
            $display("FAIL w_first_strb: got resp=%b data=%h, expected 00/1255", resp, data);
        end
        axi_write(8'h18, 32'h0000_ABCD, 4'hF, 0, 0, resp);
        vectors++;
        if (resp !== 2'b10) begin
            miscompares++;
            $display("FAIL unmapped_bresp: got %b, expected 10", resp);
        end
        axi_read(8'h08, resp, data);
        vectors++;
        if (data !== 32'h1255) begin
            miscompares++;
            $display("FAIL unmapped_dropped: CLK_DIV got %h, expected 1255", data);
        end
        axi_read(8'h14, resp, data);
        vectors++;
        if ({resp, data} !== {2'b10, 32'h0}) begin
            miscompares++;
            $display("FAIL unmapped_read: got resp=%b data=%h, expected 10/0", resp, data);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [1:0]  resp;
        logic [31:0] data;
        int          s;
        axi_write(8'h08, 32'h2, 4'hF, 0, 0, resp);
        axi_write(8'h00, 32'h3, 4'hF, 0, 0, resp);
        s = hs_falls;
        wait_falls(s + 1);
        repeat (2) @(negedge aclk);
        areset = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        vectors++;
        if (adc_clk !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_adc_clk: got %b, expected 0", adc_clk);
        end
        areset = 1'b0;
        axi_read(8'h04, resp, data);
        vectors++;
        if (data !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_stat: got %h, expected 0", data);
        end
        axi_read(8'h08, resp, data);
        vectors++;
        if (data !== 32'h4) begin
            miscompares++;
            $display("FAIL rst_clkdiv: got %h, expected 4", data);
        end
        axi_read(8'h0C, resp, data);
        vectors++;
        if (data !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_data: got %h, expected 0", data);
        end
        axi_read(8'h00, resp, data);
        vectors++;
        if (data !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_ctl: got %h, expected 0", data);
        end
    endtask

    initial begin
        test_reset();
        test_clock_div();
        test_conversion();
        test_start_ignored();
        test_bus_ordering();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
